// File: rtl/sync_fifo_ex.sv
// sync_fifo_ex: parametrised synchronous FIFO for the I2C monitor capture path
// (decoder -> FIFO -> UART/host readout).
//
// All 2**ADDR_WIDTH entries are usable because the pointers carry an extra
// wrap bit. FWFT selects one of two read modes:
//   FWFT=0: standard read. o_data is loaded from memory on an accepted read.
//   FWFT=1: first-word-fall-through. The head word sits in an output register
//           with a valid bit, and o_empty is the inverse of that bit.
//
// Ports
//   i_clk          clock; all logic is on the rising edge
//   i_rst          synchronous active-high reset (highest priority)
//   i_flush        synchronous discard of all contents (below i_rst)
//   i_clr_err      clears o_overflow/o_underflow (a new set wins)
//   i_wen, i_data  write request and write data
//   i_ren          read request (pop)
//   o_data         read data / head word
//   o_full         o_count == DEPTH
//   o_empty        no readable word
//   o_almost_full  o_count >= AFULL_TH
//   o_almost_empty o_count <= AEMPTY_TH
//   o_overflow     sticky: write attempted while full
//   o_underflow    sticky: read attempted while empty
//   o_count        words held, 0..DEPTH (includes the FWFT output register)
//
// Handshake: i_wen and i_ren are requests, and o_full and o_empty play the
// role of an inverted ready. A write is taken on an edge where
// i_wen=1 && o_full=0, and a read on an edge where i_ren=1 && o_empty=0. Both
// flags come from registered state only. A request made against the blocking
// flag is dropped and sets the matching sticky error. While i_flush=1 every
// request is ignored and sets no error.
module sync_fifo_ex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_wen,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  input  logic                  i_ren,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic                  o_underflow,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]         wptr;
  logic [CW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  ovf;
  logic                  unf;

  logic                  mem_empty;
  logic                  full_int;
  logic                  empty_int;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_pop;
  logic                  ovf_set;
  logic                  unf_set;

  always_comb begin
    mem_empty = (wptr == rptr);
    // In FWFT=0 count equals the pointer distance, so this is the same as
    // "addresses equal, wrap bits differ". In FWFT=1 the count also includes
    // the output register, which keeps o_full meaning count == DEPTH.
    full_int  = (count == DEPTH_C);
    empty_int = (FWFT != 0) ? ~dout_valid : mem_empty;

    wr_acc    = i_wen & ~full_int  & ~i_flush;
    rd_acc    = i_ren & ~empty_int & ~i_flush;

    // mem_pop moves a word from memory into dout. In FWFT=1 it refills the
    // output register whenever the register is empty or is being popped this
    // cycle, so back-to-back pops run without a bubble.
    if (FWFT != 0) begin
      mem_pop = ~mem_empty & (~dout_valid | rd_acc) & ~i_flush;
    end else begin
      mem_pop = rd_acc;
    end

    ovf_set   = i_wen & full_int  & ~i_flush;
    unf_set   = i_ren & empty_int & ~i_flush;
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (i_flush) begin
      // dout keeps its value; only the occupancy state is discarded.
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (mem_pop) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr[ADDR_WIDTH-1:0]];
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      if (FWFT != 0) begin
        if (mem_pop) begin
          dout_valid <= 1'b1;
        end else if (rd_acc) begin
          dout_valid <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags: a set in the same cycle as i_clr_err wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (i_clr_err) begin
        ovf <= 1'b0;
      end
      if (unf_set) begin
        unf <= 1'b1;
      end else if (i_clr_err) begin
        unf <= 1'b0;
      end
    end
  end

  assign o_data         = dout;
  assign o_count        = count;
  assign o_full         = full_int;
  assign o_empty        = empty_int;
  assign o_almost_full  = (count >= AFULL_C);
  assign o_almost_empty = (count <= AEMPTY_C);
  assign o_overflow     = ovf;
  assign o_underflow    = unf;

endmodule

// File: tb/tb_sync_fifo_ex.sv
// Bench for sync_fifo_ex: one FWFT=0 instance (u_std) and one FWFT=1 instance
// (u_fwft), both depth 8 with AFULL_TH=6 and AEMPTY_TH=1.
module tb_sync_fifo_ex;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          flush0, clr0, wen0, ren0;
  logic [DW-1:0] din0, data0;
  logic          full0, afull0, ovf0, empty0, aempty0, unf0;
  logic [CW-1:0] count0;

  logic          flush1, clr1, wen1, ren1;
  logic [DW-1:0] din1, data1;
  logic          full1, afull1, ovf1, empty1, aempty1, unf1;
  logic [CW-1:0] count1;

  sync_fifo_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                 .AFULL_TH(6), .AEMPTY_TH(1)) u_std (
    .i_clk(clk), .i_rst(rst), .i_flush(flush0), .i_clr_err(clr0),
    .i_wen(wen0), .i_data(din0), .o_full(full0), .o_almost_full(afull0),
    .o_overflow(ovf0), .i_ren(ren0), .o_data(data0), .o_empty(empty0),
    .o_almost_empty(aempty0), .o_underflow(unf0), .o_count(count0)
  );

  sync_fifo_ex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                 .AFULL_TH(6), .AEMPTY_TH(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_flush(flush1), .i_clr_err(clr1),
    .i_wen(wen1), .i_data(din1), .o_full(full1), .o_almost_full(afull1),
    .o_overflow(ovf1), .i_ren(ren1), .o_data(data1), .o_empty(empty1),
    .o_almost_empty(aempty1), .o_underflow(unf1), .o_count(count1)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard mode: a read taken at an edge presents its word after that
  // edge, so the compare runs one negedge after the request was seen.
  bit pend0 = 1'b0;
  always @(negedge clk) begin
    if (pend0) begin
      if (exp_q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd0_unexpected: got 0x%0h with no word expected at %0t", data0, $time);
      end else begin
        chk("rd0_data", data0, exp_q0.pop_front());
      end
    end
    pend0 = ren0 && !empty0 && !flush0 && !rst;
  end

  // FWFT mode: the head word is on o_data while o_empty=0, so a pop is
  // compared in the cycle it is requested.
  always @(negedge clk) begin
    if (ren1 && !empty1 && !flush1 && !rst) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd1_unexpected: got 0x%0h with no word expected at %0t", data1, $time);
      end else begin
        chk("rd1_data", data1, exp_q1.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [DW-1:0] d, input bit acc);
    wen0 = 1'b1;
    din0 = d;
    if (acc) exp_q0.push_back(d);
    cyc();
    wen0 = 1'b0;
  endtask

  task automatic wr1(input logic [DW-1:0] d, input bit acc);
    wen1 = 1'b1;
    din1 = d;
    if (acc) exp_q1.push_back(d);
    cyc();
    wen1 = 1'b0;
  endtask

  task automatic clr_err0();
    clr0 = 1'b1;
    cyc();
    clr0 = 1'b0;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_count0"},  count0,  0);
    chk({tag, "_empty0"},  empty0,  1);
    chk({tag, "_full0"},   full0,   0);
    chk({tag, "_data0"},   data0,   0);
    chk({tag, "_ovf0"},    ovf0,    0);
    chk({tag, "_unf0"},    unf0,    0);
    chk({tag, "_aempty0"}, aempty0, 1);
    chk({tag, "_afull0"},  afull0,  0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    flush0 = 0; clr0 = 0; wen0 = 0; ren0 = 0; din0 = '0;
    flush1 = 0; clr1 = 0; wen1 = 0; ren1 = 0; din1 = '0;
    repeat (2) cyc();
    chk_reset0("rst");
    chk("rst_count1", count1, 0);
    chk("rst_empty1", empty1, 1);
    chk("rst_data1",  data1,  0);
    rst = 1'b0;
    cyc();

    // Fill/drain with thresholds, standard mode.
    for (int i = 0; i < 8; i++) begin
      wr0(8'h10 + 8'(i), 1'b1);
      chk("fill_count", count0, i + 1);
      chk("fill_afull", afull0, (i + 1) >= 6);
      chk("fill_aempty", aempty0, (i + 1) <= 1);
    end
    chk("fill_full", full0, 1);
    wr0(8'hAA, 1'b0);
    chk("over_ovf", ovf0, 1);
    chk("over_count", count0, 8);
    clr_err0();
    chk("clr_ovf", ovf0, 0);
    ren0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("drain_count", count0, 7 - i);
      chk("drain_afull", afull0, (7 - i) >= 6);
      chk("drain_aempty", aempty0, (7 - i) <= 1);
    end
    chk("drain_empty", empty0, 1);
    cyc();
    chk("under_unf", unf0, 1);
    chk("under_data_hold", data0, 8'h17);
    ren0 = 1'b0;
    clr_err0();
    chk("clr_unf", unf0, 0);

    // Simultaneous read+write at empty, mid-level and full.
    wen0 = 1'b1; ren0 = 1'b1; din0 = 8'h30; exp_q0.push_back(8'h30);
    cyc();
    wen0 = 1'b0; ren0 = 1'b0;
    chk("both_empty_count", count0, 1);
    chk("both_empty_unf", unf0, 1);
    clr_err0();
    for (int i = 1; i < 4; i++) wr0(8'h30 + 8'(i), 1'b1);
    chk("mid_count", count0, 4);
    wen0 = 1'b1; ren0 = 1'b1;
    for (int i = 4; i < 6; i++) begin
      din0 = 8'h30 + 8'(i);
      exp_q0.push_back(din0);
      cyc();
      chk("both_mid_count", count0, 4);
    end
    wen0 = 1'b0; ren0 = 1'b0;
    for (int i = 6; i < 10; i++) wr0(8'h30 + 8'(i), 1'b1);
    chk("both_full_pre", full0, 1);
    wen0 = 1'b1; ren0 = 1'b1; din0 = 8'hBB;
    cyc();
    wen0 = 1'b0;
    chk("both_full_count", count0, 7);
    chk("both_full_ovf", ovf0, 1);
    repeat (7) cyc();
    chk("both_drain_empty", empty0, 1);
    ren0 = 1'b0;
    cyc();
    clr_err0();

    // Wrap-around: three fill/drain passes.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) wr0(8'h40 + 8'(p * 8 + i), 1'b1);
      chk("wrap_full", full0, 1);
      chk("wrap_not_empty", empty0, 0);
      ren0 = 1'b1;
      repeat (8) cyc();
      ren0 = 1'b0;
      chk("wrap_empty", empty0, 1);
      chk("wrap_not_full", full0, 0);
    end
    cyc();

    // Flush with a write in the same cycle.
    for (int i = 0; i < 5; i++) wr0(8'h60 + 8'(i), 1'b1);
    chk("pre_flush_count", count0, 5);
    flush0 = 1'b1; wen0 = 1'b1; din0 = 8'hCC;
    exp_q0.delete();
    cyc();
    flush0 = 1'b0; wen0 = 1'b0;
    chk("flush_count", count0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_ovf", ovf0, 0);
    chk("flush_unf", unf0, 0);
    chk("flush_data_hold", data0, 8'h57);
    wr0(8'h70, 1'b1);
    chk("post_flush_count", count0, 1);
    ren0 = 1'b1;
    cyc();
    ren0 = 1'b0;
    cyc();
    chk("post_flush_empty", empty0, 1);

    // Clear in the same cycle as a new overflow: the set wins.
    for (int i = 0; i < 8; i++) wr0(8'h80 + 8'(i), 1'b1);
    wen0 = 1'b1; clr0 = 1'b1; din0 = 8'hDD;
    cyc();
    wen0 = 1'b0; clr0 = 1'b0;
    chk("clr_vs_set_ovf", ovf0, 1);
    ren0 = 1'b1;
    repeat (8) cyc();
    ren0 = 1'b0;
    cyc();

    // Reset mid-fill.
    for (int i = 0; i < 3; i++) wr0(8'hA0 + 8'(i), 1'b1);
    chk("midfill_count", count0, 3);
    rst = 1'b1; wen0 = 1'b1; din0 = 8'hEE;
    exp_q0.delete();
    cyc();
    rst = 1'b0; wen0 = 1'b0;
    chk_reset0("midrst");
    chk("midrst_ovf_cleared", ovf0, 0);

    // FWFT: fall-through latency, then streaming with no bubble.
    wr1(8'h5A, 1'b1);
    chk("fwft_lat_empty", empty1, 1);
    chk("fwft_lat_count", count1, 1);
    wen1 = 1'b1; din1 = 8'h01; exp_q1.push_back(8'h01);
    cyc();
    chk("fwft_head_empty", empty1, 0);
    chk("fwft_head_data", data1, 8'h5A);
    chk("fwft_head_count", count1, 2);
    ren1 = 1'b1;
    for (int d = 2; d <= 6; d++) begin
      din1 = 8'(d);
      exp_q1.push_back(din1);
      cyc();
      chk("fwft_nogap", empty1, 0);
      chk("fwft_stream_count", count1, 2);
    end
    wen1 = 1'b0;
    cyc();
    chk("fwft_tail_count", count1, 1);
    chk("fwft_tail_empty", empty1, 0);
    cyc();
    chk("fwft_end_count", count1, 0);
    chk("fwft_end_empty", empty1, 1);
    ren1 = 1'b0;

    // FWFT: full includes the output register word; overflow; underflow.
    for (int i = 0; i < 8; i++) begin
      wr1(8'h90 + 8'(i), 1'b1);
      chk("fwft_fill_count", count1, i + 1);
    end
    chk("fwft_full", full1, 1);
    wr1(8'hAB, 1'b0);
    chk("fwft_ovf", ovf1, 1);
    chk("fwft_ovf_count", count1, 8);
    ren1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("fwft_drain_count", count1, 7 - i);
    end
    chk("fwft_drain_empty", empty1, 1);
    cyc();
    ren1 = 1'b0;
    chk("fwft_unf", unf1, 1);
    cyc();

    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ex.md
# sync_fifo_ex

Parametrised synchronous FIFO, the second-generation buffer for the I2C monitor capture path (decoder → FIFO → UART/host readout). It uses all 2**ADDR_WIDTH entries, and has a selectable first-word-fall-through read mode. It exports an occupancy count and programmable almost-full/almost-empty flags. It also provides a synchronous flush and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8: word width in bits
- ADDR_WIDTH, 11: log2 of depth; DEPTH = 2**ADDR_WIDTH words (2048)
- FWFT, 0: 0 = standard read (data registered after pop); 1 = first-word-fall-through
- AFULL_TH, 2**ADDR_WIDTH-4: o_almost_full asserted when count >= AFULL_TH
- AEMPTY_TH, 4: o_almost_empty asserted when count <= AEMPTY_TH

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_flush  in  1  synchronous discard of all contents
- i_clr_err  in  1  clears o_overflow/o_underflow
- i_wen  in  1  write request
- i_data  in  DATA_WIDTH  write data
- o_full  out  1  count == DEPTH
- o_almost_full  out  1  count >= AFULL_TH
- o_overflow  out  1  sticky: write attempted while full
- i_ren  in  1  read request (pop)
- o_data  out  DATA_WIDTH  read data
- o_empty  out  1  no readable word (see FWFT)
- o_almost_empty  out  1  count <= AEMPTY_TH
- o_underflow  out  1  sticky: read attempted while empty
- o_count  out  ADDR_WIDTH+1  words held, 0..DEPTH

## Operation
- Pointers are ADDR_WIDTH+1 bits. The MSB is the wrap bit, so all DEPTH entries are usable. Empty when pointers are equal. Full when the addresses are equal and the wrap bits differ. Pointers wrap modulo 2**(ADDR_WIDTH+1).
- Write accepted iff i_wen & ~o_full; the word is stored at the write address and the write pointer increments.
- Read accepted iff i_ren & ~o_empty; the read pointer increments.
- All flags decide on the registered state of the current cycle:
  - Full with simultaneous i_wen & i_ren: the read is accepted and the write is dropped (overflow set).
  - Empty with simultaneous i_wen & i_ren: the write is accepted and the read is rejected (underflow set).
- Otherwise, a simultaneous accepted read and write leaves o_count unchanged.
- o_count is registered: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- o_almost_full and o_almost_empty are combinational from the registered o_count. o_full and o_empty are derived from registered state only; there is no i_wen/i_ren combinational path to any output.
- FWFT=0:
  - o_data is loaded with mem[raddr] on an accepted read and holds otherwise.
  - o_empty reflects the memory occupancy.
- FWFT=1:
  - An output register holds the head word plus a valid bit.
  - o_empty = ~valid, and o_data is the head word whenever o_empty=0.
  - i_ren pops the head; the next word is prefetched from memory when available.
  - o_count includes the word in the output register; o_full still means o_count == DEPTH.
- Error flags: each is set on a rejected request and held until i_clr_err or i_rst. If set and clear occur in the same cycle, set wins.
- Flush (i_flush=1):
  - Clears pointers, o_count and the FWFT valid bit at the next edge.
  - i_wen/i_ren in the same cycle are ignored and do not set the error flags.
  - o_data holds its value in FWFT=0.
  - Priority order: i_rst > i_flush > normal operation.

## Timing
- Reset values: o_count=0, o_empty=1, o_full=0, o_data=0, o_overflow=0, o_underflow=0, o_almost_empty=1, o_almost_full=(AFULL_TH==0).
- Write to count: a write accepted at edge N shows in o_count after edge N.
- FWFT=0, read from empty:
  - o_empty falls after edge N (the write edge).
  - A read accepted at edge N+1 presents the data after edge N+1, i.e. 1-cycle read latency.
- FWFT=1, read from empty: a write at edge N gives o_empty=0 with o_data valid after edge N+1, i.e. 2-edge fall-through latency.
- FWFT=1, back-to-back pops: one word per cycle is sustained, with no bubble while the memory holds data.
- Throughput: one write and one read per cycle in both modes.
- Reset or flush mid-stream: the FIFO is empty after the edge, and the next write behaves as from reset.

## Test plan
- Fill/drain, FWFT=0, DATA_WIDTH=8, ADDR_WIDTH=3:
  - Write 0x10..0x17 → o_full=1 and o_count=8.
  - A 9th write (0xAA) → dropped, o_overflow=1.
  - Read 8 → 0x10..0x17 in order, each 1 cycle after its i_ren; o_empty=1 after the last read.
  - A 9th read → o_underflow=1 and o_data stays 0x17.
- FWFT=1:
  - Write 0x5A at edge N → o_empty=0 and o_data=0x5A after edge N+1.
  - Continuous writes 0x01..0x06 with i_ren held high → reads return 0x5A, 0x01..0x06 one per cycle, with no gaps once primed.
- Simultaneous read and write at each boundary:
  - Full + i_wen&i_ren → o_count 8→7, o_overflow=1.
  - Empty + both → o_count 0→1, o_underflow=1.
  - Mid-level (count=4) + both → count stays 4, data order preserved.
- Wrap-around: 3 full fill/drain cycles of depth 8 (24 words with incrementing values) → every word is read back in order, and o_full/o_empty are correct on each pass.
- Thresholds, AFULL_TH=6 and AEMPTY_TH=1:
  - o_almost_full rises at count=6 and falls at count=5.
  - o_almost_empty is high at counts 0..1 and low at count 2.
- Flush and reset:
  - i_flush with count=5 and i_wen=1 in the same cycle → count=0, o_empty=1, no error flags.
  - i_clr_err asserted together with a new overflow → the flag stays 1.
  - i_rst mid-fill → all outputs return to their reset values next edge.
